// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected classifier tail.
package fc_pkg;

  localparam int unsigned FC_DATA_W      = 16;
  localparam int unsigned FC_NUM_CLASSES = 10;
  localparam int unsigned FC_IDX_W       = 4;

  typedef logic signed [FC_DATA_W-1:0] logit_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/fc_logit_buf.sv
// Per-frame logit register file: one write port, one registered read port.
module fc_logit_buf
  import fc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = FC_NUM_CLASSES,
  parameter int unsigned DATA_W      = FC_DATA_W,
  parameter int unsigned IDX_W       = FC_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [NUM_CLASSES];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage is deliberately not reset so a frame survives for host readback.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < IDX_W'(NUM_CLASSES))) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_addr < IDX_W'(NUM_CLASSES)) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_argmax_classifier.sv
// Streaming argmax over one frame of FC2 logits with a debug readback buffer.
module fc_argmax_classifier
  import fc_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = FC_NUM_CLASSES,
  parameter int unsigned DATA_W      = FC_DATA_W,
  parameter int unsigned IDX_W       = FC_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic [DATA_W-1:0] out_score,
  output logic              out_err,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  argmax_state_t            state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     err_q, err_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q, in_ready_d;

  logic                     accept;
  logic                     buf_we;
  logic [IDX_W-1:0]         cnt_inc;

  assign accept  = in_valid && in_ready_q;
  assign cnt_inc = cnt_q + IDX_W'(1);

  // Next-state, running max and handshake control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    idx_d       = idx_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    buf_we      = 1'b0;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          buf_we = 1'b1;
          cnt_d  = cnt_inc;
          // Strict greater-than keeps the lowest index on ties.
          if ((cnt_q == '0) || ($signed(in_data) > max_q)) begin
            max_d = $signed(in_data);
            idx_d = cnt_q;
          end
          if (in_last) begin
            state_d     = EMIT;
            err_d       = (cnt_inc != IDX_W'(NUM_CLASSES));
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else if (cnt_inc == IDX_W'(NUM_CLASSES)) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d     = ACCUM;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ACCUM;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  fc_logit_buf #(
    .NUM_CLASSES (NUM_CLASSES),
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W)
  ) u_logit_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_we),
    .wr_addr (cnt_q),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = idx_q;
  assign out_score = max_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed and randomized checks of fc_argmax_classifier against a frame-level model.
module tb_fc_argmax_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic [15:0] out_score;
  logic        out_err;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] cur[$];
  logic [15:0] mbuf [10];
  int          exp_class;
  logic [15:0] exp_score;
  logic        exp_err;

  fc_argmax_classifier dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_err   (out_err),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: argmax over the first min(len,10) beats, lowest index wins ties.
  task automatic model(input int len);
    int n;
    int best;
    n = (len < 10) ? len : 10;
    best = 0;
    for (int i = 0; i < n; i++) begin
      if ($signed(cur[i]) > $signed(cur[best])) best = i;
      mbuf[i] = cur[i];
    end
    exp_class = best;
    exp_score = cur[best];
    exp_err   = (len != 10);
  endtask

  task automatic make_frame(input int len);
    cur.delete();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 2) == 0) cur.push_back(16'($urandom_range(0, 3)) << 8);
      else                           cur.push_back(16'($urandom));
    end
  endtask

  task automatic drive(input int len, input bit gaps, input bit with_last);
    int gap;
    int t;
    for (int i = 0; i < len; i++) begin
      gap = 0;
      if (gaps && ($urandom_range(0, 2) == 0)) gap = $urandom_range(1, 3);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = cur[i];
      in_last  = with_last && (i == len - 1);
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_class"}, 32'(out_class), 32'(exp_class));
    chk({tag, "_score"}, 32'(out_score), 32'(exp_score));
    chk({tag, "_err"},   32'(out_err),   32'(exp_err));
    chk({tag, "_inrdy"}, 32'(in_ready),  32'd0);
  endtask

  task automatic hold_and_release(input string tag, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_class"}, 32'(out_class), 32'(exp_class));
      chk({tag, "_hold_score"}, 32'(out_score), 32'(exp_score));
      chk({tag, "_hold_inrdy"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_inrdy"}, 32'(in_ready),  32'd1);
    out_ready = 1'b0;
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk({tag, "_rd"}, 32'(rd_data), 32'(mbuf[a]));
    end
    rd_addr = 4'd12;
    @(negedge clk);
    chk({tag, "_rd_oor"}, 32'(rd_data), 32'd0);
    chk({tag, "_rd_still_valid"}, 32'(out_valid), 32'd1);
    rd_addr = 4'd0;
  endtask

  initial begin
    int len;
    int hold;
    int v1[10];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rd_addr   = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_score", 32'(out_score), 32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: reference frame with out_ready high throughout.
    v1 = '{3, -1, 7, 2, 7, 0, -5, 1, 4, 6};
    cur.delete();
    foreach (v1[i]) cur.push_back(16'(v1[i] * 256));
    model(10);
    out_ready = 1'b1;
    drive(10, 1'b0, 1'b1);
    chk("t1_exp_class", 32'(exp_class), 32'd2);
    check_result("t1");
    hold_and_release("t1", 0);

    // 2: all most-negative logits.
    cur.delete();
    repeat (10) cur.push_back(16'h8000);
    model(10);
    drive(10, 1'b0, 1'b1);
    check_result("t2");
    chk("t2_fixed_score", 32'(out_score), 32'h8000);
    chk("t2_fixed_class", 32'(out_class), 32'd0);
    hold_and_release("t2", 1);

    // 3a: short frame 1..5.
    cur.delete();
    for (int i = 1; i <= 5; i++) cur.push_back(16'(i * 256));
    model(5);
    drive(5, 1'b0, 1'b1);
    check_result("t3a");
    hold_and_release("t3a", 0);

    // 3b: long frame of 12 beats, last two dropped.
    make_frame(12);
    cur[11] = 16'h7fff;
    model(12);
    drive(12, 1'b0, 1'b1);
    check_result("t3b");
    readback("t3b");
    hold_and_release("t3b", 0);

    // Single-beat frame.
    cur.delete();
    cur.push_back(16'hfe80);
    model(1);
    drive(1, 1'b0, 1'b1);
    check_result("t1beat");
    hold_and_release("t1beat", 0);

    // 4: backpressure for 20 cycles.
    make_frame(10);
    model(10);
    drive(10, 1'b0, 1'b1);
    check_result("t4");
    hold_and_release("t4", 20);

    // 5: random frames with input gaps and output backpressure.
    for (int f = 0; f < 100; f++) begin
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 13) : 10;
      make_frame(len);
      model(len);
      drive(len, 1'b1, 1'b1);
      check_result("t5");
      if (f % 4 == 0) readback("t5");
      hold = $urandom_range(0, 3);
      hold_and_release("t5", hold);
    end

    // 6: reset after six beats of a frame.
    make_frame(10);
    model(6);
    drive(6, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_inrdy", 32'(in_ready),  32'd1);
    chk("t6_rst_class", 32'(out_class), 32'd0);
    chk("t6_rst_score", 32'(out_score), 32'd0);
    chk("t6_rst_rd",    32'(rd_data),   32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_valid", 32'(out_valid), 32'd0);
    end
    make_frame(10);
    model(10);
    drive(10, 1'b1, 1'b1);
    check_result("t6");
    readback("t6");
    hold_and_release("t6", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
